regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Shares the register file's single write port and single system-bus read port among `N_REQ` requesters, such as the load unit, the debug/system-bus master and the writeback path. Each requester presents one read or write transaction with a valid/ready handshake. A round-robin arbiter grants at most one transaction per cycle and drives the register file's `select_write`, `systembus_in` and `select_sbus` from registered outputs. Read data is returned to the requester two cycles after grant. The `select_alu` port is not touched.

## Interface
- `N_REQ`, default 3: number of requesters, 2..8.
- `DW`, default 32: data width; must match the register file.
- `AW`, default 5: register address width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in `N_REQ`: per-requester transaction valid.
- `req_write` in `N_REQ`: 1 = write, 0 = read.
- `req_addr` in `N_REQ*AW`: register index; requester i occupies slice i.
- `req_wdata` in `N_REQ*DW`: write data; requester i occupies slice i.
- `req_lock` in `N_REQ`: hold grant after this transaction. Only used when `REGFILE_ARB_LOCK_EN` is defined.
- `req_ready` out `N_REQ`: grant, one-hot or zero, combinational from `req_valid` and arbiter state.
- `rsp_valid` out `N_REQ`: read-data-valid, one-hot, registered.
- `rsp_data` out `DW`: read data shared by all requesters; qualified by `rsp_valid`.
- `rf_select_write` out `AW`: to register file `select_write`.
- `rf_wdata` out `DW`: to register file `systembus_in`.
- `rf_select_sbus` out `AW`: to register file `select_sbus`.
- `rf_rdata` in `DW`: from register file `systembus_out`.

## Operation
- A transaction transfers in cycle T when `req_valid[i]` and `req_ready[i]` are both high. The requester must hold its valid, write, address and data fields stable until ready is seen.
- Arbitration is round-robin. The search starts at `rr_ptr` and wraps from `N_REQ-1` to 0. The first requester with valid asserted wins.
- After each transfer, `rr_ptr` becomes the winner's index + 1, modulo `N_REQ`. With no transfer, `rr_ptr` holds.
- Issue stage, registered at the end of T:
  - **Write:** `rf_select_write` = address and `rf_wdata` = data for cycle T+1 only. `rf_select_write` returns to 0 in every cycle with no write issuing. This is mandatory: the register file writes continuously while the select is nonzero.
  - **Read:** `rf_select_sbus` = address for cycle T+1. It holds its last value when idle.
- Response stage: `rf_rdata` is registered at the end of T+1 into `rsp_data`. `rsp_valid[winner]` is high for exactly cycle T+2. There is no backpressure; requesters must accept the response.
- Register 0:
  - Writes to register 0 are accepted and completed but have no effect, because `select_write` = 0 is the register file's no-op.
  - Reads of register 0 return 0.
- Read-after-write: a write granted in T followed by a read of the same register granted in T+1 returns the new data. The register file is combinational, so no forwarding logic is needed.
- Throughput is one transaction per cycle. Reads and writes may interleave every cycle.
- Reset drives all outputs and state to 0: `req_ready`, `rsp_valid`, `rsp_data`, `rf_select_write`, `rf_wdata`, `rf_select_sbus`, and `rr_ptr`, plus `lock_owner`/state when locking is enabled.
- A reset asserted mid-operation cancels in-flight writes and responses. `rf_select_write` goes to 0 asynchronously.

## Timing
- Grant, issue and response latencies, with transfer in cycle T:
  - Grant: combinational in cycle T.
  - Register file write: takes effect during T+1.
  - Read response: arrives in T+2.
- Lock state machine, present only with `REGFILE_ARB_LOCK_EN`:
  - **UNLOCKED:** normal round-robin. A transfer with `req_lock[i]`=1 moves to LOCKED with `lock_owner` = i.
  - **LOCKED:** only `lock_owner` may receive ready; all others see ready = 0. A transfer from the owner with `req_lock`=0 returns to UNLOCKED, and `rr_ptr` = owner + 1.
  - Deasserting `req_valid` while LOCKED keeps the lock.
- Simultaneous valids from every requester give one grant per cycle in strict rotation.

## Configuration
- `REGFILE_ARB_LOCK_EN` defined:
  - `req_lock` is honoured as described in Timing, enabling atomic read-modify-write sequences.
- Undefined:
  - `req_lock` is ignored and there is no lock state; arbitration is pure round-robin.
  - Port list unchanged.

## Structure
- Shared package `regfile_pkg`:
  - `REG_AW`=5, `REG_DW`=32, `REG_ZERO`=0.
  - Lock state enum `{ARB_UNLOCKED, ARB_LOCKED}`.
- Sub-module `rr_arbiter`: parameter `N`; inputs `req[N]` and `ptr`; outputs one-hot `gnt[N]` and `gnt_idx`. Purely combinational and reused elsewhere.
- The top level holds the pointer, the lock FSM, the issue registers and the response registers.

## Test plan
- Write then read. Requester 0 writes register 5 = 0xDEADBEEF, then reads register 5:
  - `rf_select_write`=5 for exactly one cycle, then 0.
  - `rsp_valid[0]` two cycles after the read grant, with `rsp_data`=0xDEADBEEF.
- Register 0. Write 0x12345678 to register 0, then read register 0:
  - `rf_select_write` stays 0.
  - `rsp_data`=0x00000000.
- Full contention. All three requesters hold valid for 6 cycles:
  - Grants follow the order 0,1,2,0,1,2.
  - Each `rsp_valid` goes to the matching requester two cycles after its grant.
- Back-to-back read-after-write. Requester 1 writes register 9 = 0xA5A5A5A5 in cycle T, and requester 2 reads register 9 in T+1:
  - `rsp_valid[2]` arrives in T+3 with `rsp_data`=0xA5A5A5A5.
- Lock, with `REGFILE_ARB_LOCK_EN`. Requester 2 reads register 3 with lock=1, while requesters 0 and 1 hold valid:
  - Requesters 0 and 1 see no ready until requester 2 writes register 3 with lock=0.
  - The next grant after the unlock goes to requester 0.
- Reset mid-write. Assert `rst_n`=0 in the cycle `rf_select_write`=7:
  - `rf_select_write`, `rsp_valid` and `rr_ptr` go to 0 immediately.
  - No response is issued after reset releases.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and arbiter lock-state type.
// The optional lock feature is enabled with REGFILE_ARB_LOCK_EN.
package regfile_pkg;

  localparam int REG_AW   = 5;
  localparam int REG_DW   = 32;
  localparam int REG_ZERO = 0;

  typedef enum logic {
    ARB_UNLOCKED,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side bundle: per-requester valid/ready transactions
// and the shared read-response bus.
interface regfile_port_arbiter_if
  import regfile_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DW    = REG_DW,
  parameter int AW    = REG_AW
) ();

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_write;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_lock;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_data;

  modport master (
    output req_valid, req_write, req_addr,
    output req_wdata, req_lock,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_lock,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and
// wraps; first active request wins.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  always_comb begin
    int idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin sharing of the register file write and system-bus read
// ports; optional grant locking under REGFILE_ARB_LOCK_EN.
module regfile_port_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int DW    = REG_DW,
  parameter int AW    = REG_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_port_arbiter_if.slave bus,
  output logic [AW-1:0]        rf_select_write,
  output logic [DW-1:0]        rf_wdata,
  output logic [AW-1:0]        rf_select_sbus,
  input  logic [DW-1:0]        rf_rdata
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    ptr_nx;
  logic [PW-1:0]    gnt_idx;
  logic [N_REQ-1:0] req_mask;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rd_pend;
  logic             xfer;
  logic             w_write;
  logic             rd_zero;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req     (req_mask),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign bus.req_ready = rst_n ? gnt : '0;
  assign xfer    = rst_n & (|gnt);
  assign w_write = bus.req_write[gnt_idx];
  assign w_addr  = bus.req_addr[int'(gnt_idx)*AW +: AW];
  assign w_data  = bus.req_wdata[int'(gnt_idx)*DW +: DW];
  assign ptr_nx  = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;

`ifdef REGFILE_ARB_LOCK_EN
  arb_state_e    state;
  arb_state_e    state_nx;
  logic [PW-1:0] lock_owner;
  logic [PW-1:0] owner_nx;

  assign req_mask = (state == ARB_LOCKED)
                  ? bus.req_valid & (N_REQ'(1) << lock_owner)
                  : bus.req_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_UNLOCKED;
      lock_owner <= '0;
    end else begin
      state      <= state_nx;
      lock_owner <= owner_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = lock_owner;
    unique case (state)
      ARB_UNLOCKED:
        if (xfer && bus.req_lock[gnt_idx]) begin
          state_nx = ARB_LOCKED;
          owner_nx = gnt_idx;
        end
      ARB_LOCKED:
        if (xfer && !bus.req_lock[gnt_idx])
          state_nx = ARB_UNLOCKED;
    endcase
  end
`else
  logic lock_unused;
  assign req_mask    = bus.req_valid;
  assign lock_unused = ^bus.req_lock;
`endif

  // select_write must drop to 0 on idle cycles: the file writes while nonzero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr          <= '0;
      rf_select_write <= '0;
      rf_wdata        <= '0;
      rf_select_sbus  <= '0;
      rd_pend         <= '0;
      rd_zero         <= 1'b0;
      bus.rsp_valid   <= '0;
      bus.rsp_data    <= '0;
    end else begin
      if (xfer)
        rr_ptr <= ptr_nx;
      rf_select_write <= (xfer && w_write) ? w_addr : '0;
      if (xfer && w_write)
        rf_wdata <= w_data;
      if (xfer && !w_write) begin
        rf_select_sbus <= w_addr;
        rd_zero        <= (w_addr == AW'(REG_ZERO));
      end
      rd_pend       <= (xfer && !w_write) ? gnt : '0;
      bus.rsp_valid <= rd_pend;
      if (|rd_pend)
        bus.rsp_data <= rd_zero ? '0 : rf_rdata;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Bench for regfile_port_arbiter: directed steps plus random traffic
// against an architectural model; lock steps under REGFILE_ARB_LOCK_EN.
module tb_regfile_port_arbiter;
  import regfile_pkg::*;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] rf_select_write;
  logic [AW-1:0] rf_select_sbus;
  logic [DW-1:0] rf_wdata;
  logic [DW-1:0] rf_rdata;

  regfile_port_arbiter_if #(.N_REQ(N), .DW(DW), .AW(AW)) ifc ();

  regfile_port_arbiter #(.N_REQ(N), .DW(DW), .AW(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (ifc.slave),
    .rf_select_write (rf_select_write),
    .rf_wdata        (rf_wdata),
    .rf_select_sbus  (rf_select_sbus),
    .rf_rdata        (rf_rdata)
  );

  // combinational register file, register 0 hardwired to zero
  logic [31:0][DW-1:0] rf_mem = '0;
  always @(posedge clk)
    if (rf_select_write != '0) rf_mem[rf_select_write] <= rf_wdata;
  assign rf_rdata = (rf_select_sbus == '0) ? '0 : rf_mem[rf_select_sbus];

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } rsp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ptr = 0;
  bit locked = 0;
  int owner = 0;
  rsp_t q[$];
  int glog[$];
  logic [DW-1:0] mregs [32];
  logic [AW-1:0] exp_sw = '0;
  logic [DW-1:0] exp_wd = '0;
  logic [DW-1:0] saved_val = '0;

  bit            vld  [N];
  bit            wr   [N];
  bit            lk   [N];
  logic [AW-1:0] addr [N];
  logic [DW-1:0] wdat [N];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      ifc.req_valid[i] = vld[i];
      ifc.req_write[i] = wr[i];
      ifc.req_lock[i]  = lk[i];
      ifc.req_addr[i*AW +: AW]  = addr[i];
      ifc.req_wdata[i*DW +: DW] = wdat[i];
    end
  endtask

  task automatic set_req(int i, bit w, int a, logic [DW-1:0] d, bit l);
    vld[i]  = 1'b1;
    wr[i]   = w;
    addr[i] = AW'(a);
    wdat[i] = d;
    lk[i]   = l;
  endtask

  function automatic int pick();
`ifdef REGFILE_ARB_LOCK_EN
    if (locked) return vld[owner] ? owner : -1;
`endif
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (vld[i]) return i;
    end
    return -1;
  endfunction

  // one clock cycle: check outputs, then advance the model on the edge
  task automatic tick();
    int w;
    logic [N-1:0] erd;
    logic [N-1:0] erv;
    drive();
    #1;
    w = pick();
    erd = (w < 0) ? '0 : N'(1) << w;
    chk("req_ready", ifc.req_ready, erd);
    erv = '0;
    if (q.size() > 0 && q[0].due == cyc) erv = N'(1) << q[0].idx;
    chk("rsp_valid", ifc.rsp_valid, erv);
    if (erv != '0) begin
      chk("rsp_data", ifc.rsp_data, q[0].data);
      void'(q.pop_front());
    end
    chk("rf_select_write", rf_select_write, exp_sw);
    if (exp_sw != '0) chk("rf_wdata", rf_wdata, exp_wd);
    @(posedge clk);
    exp_sw = '0;
    if (w >= 0) begin
      glog.push_back(w);
      if (wr[w]) begin
        exp_sw = addr[w];
        exp_wd = wdat[w];
        saved_val = mregs[addr[w]];
        if (addr[w] != '0) mregs[addr[w]] = wdat[w];
      end else begin
        q.push_back('{cyc + 2, w, mregs[addr[w]]});
      end
      ptr = (w + 1) % N;
`ifdef REGFILE_ARB_LOCK_EN
      if (!locked && lk[w]) begin
        locked = 1'b1;
        owner  = w;
      end else if (locked && !lk[w]) begin
        locked = 1'b0;
      end
`endif
      vld[w] = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0;
      lk[i]  = 1'b0;
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b1; wr[i] = 1'b0; lk[i] = 1'b0;
      addr[i] = AW'(i + 1); wdat[i] = '0;
    end
    drive();

    // reset state, with every requester valid
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", ifc.req_ready, '0);
    chk("rst_rsp_valid", ifc.rsp_valid, '0);
    chk("rst_rsp_data", ifc.rsp_data, '0);
    chk("rst_sel_write", rf_select_write, '0);
    chk("rst_wdata", rf_wdata, '0);
    chk("rst_sel_sbus", rf_select_sbus, '0);
    clear_reqs();
    rst_n = 1'b1;

    // full contention: strict rotation from pointer 0
    glog.delete();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++)
        if (!vld[i]) set_req(i, 0, $urandom_range(1, 31), '0, 0);
      tick();
    end
    for (int k = 0; k < 6; k++) chk("rr_order", glog[k], k % N);
    clear_reqs();
    repeat (3) tick();

    // write then read register 5
    set_req(0, 1, 5, 32'hDEADBEEF, 0);
    tick();
    chk("wr5_sel", rf_select_write, 5);
    set_req(0, 0, 5, '0, 0);
    tick();
    chk("wr5_sel_clear", rf_select_write, 0);
    tick();
    chk("rd5_valid", ifc.rsp_valid, 3'b001);
    chk("rd5_data", ifc.rsp_data, 32'hDEADBEEF);
    repeat (2) tick();

    // register 0 write is a no-op, read returns zero
    set_req(1, 1, 0, 32'h12345678, 0);
    tick();
    chk("wr0_sel", rf_select_write, 0);
    set_req(1, 0, 0, '0, 0);
    tick();
    tick();
    chk("rd0_valid", ifc.rsp_valid, 3'b010);
    chk("rd0_data", ifc.rsp_data, 0);
    repeat (2) tick();

    // back-to-back read-after-write on register 9
    set_req(1, 1, 9, 32'hA5A5A5A5, 0);
    tick();
    set_req(2, 0, 9, '0, 0);
    tick();
    tick();
    chk("raw_valid", ifc.rsp_valid, 3'b100);
    chk("raw_data", ifc.rsp_data, 32'hA5A5A5A5);
    repeat (2) tick();

    // reset while a write to register 7 is being issued
    set_req(0, 1, 7, 32'h11111111, 0);
    tick();
    repeat (2) tick();
    set_req(1, 0, 4, '0, 0);
    tick();
    set_req(0, 1, 7, 32'hBADBAD00, 0);
    tick();
    chk("mid_sel7", rf_select_write, 7);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", rf_select_write, 0);
    chk("mid_rst_rsp", ifc.rsp_valid, 0);
    chk("mid_rst_wdata", rf_wdata, 0);
    if (exp_sw != '0) mregs[exp_sw] = saved_val;
    exp_sw = '0;
    q.delete();
    ptr = 0;
    locked = 1'b0;
    clear_reqs();
    drive();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    repeat (3) tick();
    set_req(0, 0, 1, '0, 0);
    set_req(1, 0, 2, '0, 0);
    set_req(2, 0, 7, '0, 0);
    drive();
    #1;
    chk("post_rst_ptr", ifc.req_ready, 3'b001);
    repeat (6) tick();

`ifdef REGFILE_ARB_LOCK_EN
    // locked read-modify-write by requester 2
    set_req(2, 0, 3, '0, 1);
    tick();
    set_req(0, 1, 4, 32'h1, 0);
    set_req(1, 0, 4, '0, 0);
    repeat (3) begin
      tick();
      drive();
      #1;
      chk("lock_block", ifc.req_ready, '0);
    end
    set_req(2, 1, 3, 32'h00C0FFEE, 0);
    tick();
    drive();
    #1;
    chk("unlock_next", ifc.req_ready, 3'b001);
    repeat (4) tick();
    clear_reqs();
    repeat (3) tick();
`endif

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!vld[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                  $urandom, ($urandom_range(0, 3) == 0));
      tick();
    end
    clear_reqs();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
